// File: rtl/ifetch_req_ctrl.sv
// ifetch_req_ctrl: instruction-fetch request controller.
// Issues one fetch request at a time on the instruction bus. It tracks
// requests that were flushed after the bus accepted them, so that their
// late data can be discarded. Returned instructions are held in a
// one-entry buffer until the IF stage can take them.
// Optional build macro IFETCH_BYPASS_EN: when defined, data arriving while
// the buffer is empty and IF can accept it goes straight to the outputs in
// the same cycle, without passing through the buffer.

module ifetch_req_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  input  logic [31:0] pc_i,
  input  logic        if_allowin_i,
  input  logic        excep_flush_i,
  input  logic        banch_flush_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [63:0] inst_rdata_i,
  output logic        preif_ready_go_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic [63:0] inst_rdata_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cancel_cnt_q, cancel_cnt_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [63:0] buf_rdata_q, buf_rdata_d;

  logic flush;
  logic issue;
  logic accept;
  logic complete;
  logic bypass;
  logic fill;
  logic cancel_inc;
  logic cancel_dec;

  // Decode the events that happen this cycle from the state and bus handshakes
  always_comb begin
    flush    = excep_flush_i | banch_flush_i;
    issue    = (state_q == IDLE) & fetch_valid_i & ~flush &
               (cancel_cnt_q < 2'd2) & (~buf_valid_q | if_allowin_i);
    accept   = (state_q == REQ) & inst_addr_ok_i;
    complete = (state_q == WAIT) & inst_data_ok_i & (cancel_cnt_q == 2'd0);
`ifdef IFETCH_BYPASS_EN
    bypass   = complete & ~buf_valid_q & if_allowin_i & ~flush;
`else
    bypass   = 1'b0;
`endif
    fill       = complete & ~flush & ~bypass;
    // A flushed request that the bus already owns must have its data dropped;
    // a request completing in the flush cycle has nothing left outstanding.
    cancel_inc = flush & (((state_q == WAIT) & ~complete) | accept);
    cancel_dec = inst_data_ok_i & (cancel_cnt_q != 2'd0);
  end

  // Next state of the request FSM; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (issue)          state_d = REQ;
        REQ:     if (inst_addr_ok_i) state_d = WAIT;
        WAIT:    if (complete)       state_d = IDLE;
        default:                     state_d = IDLE;
      endcase
    end
  end

  // Count of outstanding requests whose data is to be thrown away
  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (cancel_inc && !cancel_dec && (cancel_cnt_q < 2'd2)) begin
      cancel_cnt_d = cancel_cnt_q + 2'd1;
    end else if (cancel_dec && !cancel_inc) begin
      cancel_cnt_d = cancel_cnt_q - 2'd1;
    end
  end

  // Request address and the one-entry instruction buffer
  always_comb begin
    addr_d      = issue ? pc_i : addr_q;
    buf_pc_d    = buf_pc_q;
    buf_rdata_d = buf_rdata_q;
    buf_valid_d = buf_valid_q;
    if (flush) begin
      buf_valid_d = 1'b0;
    end else if (fill) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = addr_q;
      buf_rdata_d = inst_rdata_i;
    end else if (buf_valid_q && if_allowin_i) begin
      buf_valid_d = 1'b0;
    end
  end

  // All state registers, cleared asynchronously by the active-high reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      cancel_cnt_q <= 2'd0;
      buf_valid_q  <= 1'b0;
      addr_q       <= 32'h1c00_0000;
      buf_pc_q     <= 32'h0;
      buf_rdata_q  <= 64'h0;
    end else begin
      state_q      <= state_d;
      cancel_cnt_q <= cancel_cnt_d;
      buf_valid_q  <= buf_valid_d;
      addr_q       <= addr_d;
      buf_pc_q     <= buf_pc_d;
      buf_rdata_q  <= buf_rdata_d;
    end
  end

  // Output drive: bus request from the FSM, instruction from buffer or bypass
  always_comb begin
    inst_req_o       = (state_q == REQ);
    inst_addr_o      = addr_q;
    preif_ready_go_o = accept & ~flush;
    inst_valid_o     = buf_valid_q | bypass;
    inst_pc_o        = bypass ? addr_q       : buf_pc_q;
    inst_rdata_o     = bypass ? inst_rdata_i : buf_rdata_q;
  end

endmodule

// File: tb/tb_ifetch_req_ctrl.sv
// Self-checking bench for ifetch_req_ctrl (default build, no bypass).
// The reference model tracks a pending address, a queue of bus-accepted
// requests each marked live or discarded, and the instruction buffer.

module tb_ifetch_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid_i;
  logic [31:0] pc_i;
  logic        if_allowin_i;
  logic        excep_flush_i;
  logic        banch_flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [63:0] inst_rdata_i;
  logic        preif_ready_go_o;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [63:0] inst_rdata_o;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] pc;
    bit          live;
  } out_t;

  bit          m_req;
  logic [31:0] m_addr;
  out_t        m_outq[$];
  bit          m_buf;
  logic [31:0] m_buf_pc;
  logic [63:0] m_buf_data;

  ifetch_req_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid_i    (fetch_valid_i),
    .pc_i             (pc_i),
    .if_allowin_i     (if_allowin_i),
    .excep_flush_i    (excep_flush_i),
    .banch_flush_i    (banch_flush_i),
    .inst_req_o       (inst_req_o),
    .inst_addr_o      (inst_addr_o),
    .inst_addr_ok_i   (inst_addr_ok_i),
    .inst_data_ok_i   (inst_data_ok_i),
    .inst_rdata_i     (inst_rdata_i),
    .preif_ready_go_o (preif_ready_go_o),
    .inst_valid_o     (inst_valid_o),
    .inst_pc_o        (inst_pc_o),
    .inst_rdata_o     (inst_rdata_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int deadCount();
    int n = 0;
    foreach (m_outq[i]) if (!m_outq[i].live) n++;
    return n;
  endfunction

  function automatic bit liveExists();
    bit found = 0;
    foreach (m_outq[i]) if (m_outq[i].live) found = 1;
    return found;
  endfunction

  task automatic modelReset();
    m_req      = 0;
    m_addr     = 32'h1c00_0000;
    m_outq.delete();
    m_buf      = 0;
    m_buf_pc   = 32'h0;
    m_buf_data = 64'h0;
  endtask

  // One clock edge of the reference model, using the inputs held this cycle
  task automatic modelUpdate();
    bit   f;
    bit   doIssue;
    bit   doFill;
    out_t e;
    f       = excep_flush_i | banch_flush_i;
    doIssue = !m_req && !liveExists() && !f && (deadCount() < 2) &&
              fetch_valid_i && (!m_buf || if_allowin_i);
    doFill  = 0;
    if (inst_data_ok_i && (m_outq.size() > 0)) begin
      e = m_outq.pop_front();
      if (e.live && !f) doFill = 1;
    end
    if (f) foreach (m_outq[i]) m_outq[i].live = 0;
    if (m_req && inst_addr_ok_i) begin
      e.pc   = m_addr;
      e.live = !f;
      m_outq.push_back(e);
      m_req = 0;
    end
    if (f) m_req = 0;
    if (doIssue) begin
      m_req  = 1;
      m_addr = pc_i;
    end
    if (f) m_buf = 0;
    else if (doFill) begin
      m_buf      = 1;
      m_buf_pc   = e.pc;
      m_buf_data = inst_rdata_i;
    end else if (if_allowin_i) m_buf = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("inst_req", 64'(inst_req_o), 64'(m_req));
    checkOutput("inst_addr", 64'(inst_addr_o), 64'(m_addr));
    checkOutput("preif_ready_go", 64'(preif_ready_go_o),
                64'(m_req && inst_addr_ok_i && !(excep_flush_i || banch_flush_i)));
    checkOutput("inst_valid", 64'(inst_valid_o), 64'(m_buf));
    checkOutput("cancel_cnt", 64'(dut.cancel_cnt_q), 64'(deadCount()));
    if (m_buf) begin
      checkOutput("inst_pc", 64'(inst_pc_o), 64'(m_buf_pc));
      checkOutput("inst_rdata", inst_rdata_o, m_buf_data);
    end
  endtask

  task automatic applyStimulus(input bit fv, input logic [31:0] pc, input bit allow,
                               input bit ef, input bit bf, input bit aok, input bit dok,
                               input logic [63:0] rdata);
    fetch_valid_i  = fv;
    pc_i           = pc;
    if_allowin_i   = allow;
    excep_flush_i  = ef;
    banch_flush_i  = bf;
    inst_addr_ok_i = aok;
    inst_data_ok_i = dok;
    inst_rdata_i   = rdata;
  endtask

  task automatic tick();
    #1 checkAll();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #1 checkAll();
    checkOutput("reset_req", 64'(inst_req_o), 64'd0);
    checkOutput("reset_addr", 64'(inst_addr_o), 64'h1c00_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    // basic fetch: addr_ok next cycle, data_ok two cycles later
    applyStimulus(1, 32'h1c00_0000, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h1111_2222_3333_4444); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("basic_valid", 64'(inst_valid_o), 64'd1);
    checkOutput("basic_pc", 64'(inst_pc_o), 64'h1c00_0000);
    checkOutput("basic_rdata", inst_rdata_o, 64'h1111_2222_3333_4444);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0); tick();

    // flush in WAIT, then the late data is discarded
    applyStimulus(1, 32'h1c00_0008, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 64'hdead_beef_0000_0001);
    #1 checkOutput("flush_cnt", 64'(dut.cancel_cnt_q), 64'd1);
    checkOutput("flush_req", 64'(inst_req_o), 64'd0);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("flush_valid", 64'(inst_valid_o), 64'd0);
    tick();

    // two cancelled requests saturate the counter and block new requests
    applyStimulus(1, 32'h1c00_0010, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 32'h1c00_0010, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(1, 32'h1c00_0010, 1, 0, 1, 0, 0, 0); tick();
    applyStimulus(1, 32'h1c00_0018, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 32'h1c00_0018, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(1, 32'h1c00_0018, 1, 0, 1, 0, 0, 0); tick();
    applyStimulus(1, 32'h1c00_0020, 1, 0, 0, 0, 0, 0); tick();
    #1 checkOutput("sat_cnt", 64'(dut.cancel_cnt_q), 64'd2);
    checkOutput("sat_req", 64'(inst_req_o), 64'd0);
    tick();
    applyStimulus(1, 32'h1c00_0020, 1, 0, 0, 0, 1, 64'h5); tick();
    applyStimulus(1, 32'h1c00_0020, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("resume_req", 64'(inst_req_o), 64'd1);
    checkOutput("resume_cnt", 64'(dut.cancel_cnt_q), 64'd1);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h6); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h0123_4567_89ab_cdef); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0); tick();

    // buffer held while IF stalls, then drain and re-request on one edge
    applyStimulus(1, 32'h1c00_0028, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'haaaa_bbbb_cccc_dddd); tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'h1c00_0030, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("stall_req", 64'(inst_req_o), 64'd0);
      checkOutput("stall_pc", 64'(inst_pc_o), 64'h1c00_0028);
      tick();
    end
    applyStimulus(1, 32'h1c00_0030, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("drain_valid", 64'(inst_valid_o), 64'd0);
    checkOutput("drain_req", 64'(inst_req_o), 64'd1);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 64'h7); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0); tick();

    // flush coincident with data_ok in WAIT drops the data
    applyStimulus(1, 32'h1c00_0038, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 64'h8); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("coinc_valid", 64'(inst_valid_o), 64'd0);
    checkOutput("coinc_cnt", 64'(dut.cancel_cnt_q), 64'd0);
    tick();

    // asynchronous reset while waiting for data
    applyStimulus(1, 32'h1c00_0040, 1, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    #1 modelReset();
    checkAll();
    checkOutput("areset_req", 64'(inst_req_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 64'h9); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("areset_valid", 64'(inst_valid_o), 64'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom % 4) != 0, $urandom & 32'hffff_fff8, ($urandom % 3) != 0,
                    ($urandom % 25) == 0, ($urandom % 15) == 0, ($urandom % 2) == 0,
                    (m_outq.size() > 0) && (($urandom % 3) == 0),
                    {$urandom, $urandom});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
